// File: rtl/mei_gateway.sv
// mei_gateway: conditions six raw external interrupt lines into pending/claim/complete state for the CSR MEI inputs
module mei_gateway #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [5:0] EDGE_MASK   = 6'b000000,
    parameter logic [5:0] IRQ_POL     = 6'b111111
) (
    input  logic       i_CLK,
    input  logic       i_RSTn,
    input  logic [5:0] i_IRQ_RAW,
    input  logic       i_CLAIM,
    input  logic       i_COMPLETE,
    input  logic [2:0] i_COMPLETE_ID,
    output logic       o_MEI_0,
    output logic       o_MEI_1,
    output logic       o_MEI_2,
    output logic       o_MEI_3,
    output logic       o_MEI_4,
    output logic       o_MEI_5,
    output logic       o_CLAIM_VALID,
    output logic [2:0] o_CLAIM_ID,
    output logic [5:0] o_IN_SERVICE
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PENDING    = 2'd1;
    localparam logic [1:0] IN_SERVICE = 2'd2;

    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic [5:0] act, prev, rise, req, pend, insvc, win;
    logic [2:0] win_id;
    logic       claim_hit;

    // synchroniser chain, parked at the inactive raw level while in reset
    always_ff @(posedge i_CLK or negedge i_RSTn)
        if (!i_RSTn) sync_q <= {SYNC_STAGES{~IRQ_POL}};
        else sync_q <= {sync_q[SYNC_STAGES-2:0], i_IRQ_RAW};

    assign act  = ~(sync_q[SYNC_STAGES-1] ^ IRQ_POL);
    assign rise = act & ~prev;
    assign req  = (EDGE_MASK & rise) | (~EDGE_MASK & act);

    // previous active sample; cleared in reset so a line active at release yields one rise
    always_ff @(posedge i_CLK or negedge i_RSTn)
        if (!i_RSTn) prev <= 6'd0;
        else prev <= act;

    assign win       = pend & (~pend + 6'd1);
    assign claim_hit = i_CLAIM & |pend;

    // encode the lowest-index pending line
    always_comb begin
        win_id = 3'd0;
        for (int i = 5; i >= 0; i--)
            if (pend[i]) win_id = 3'(i);
    end

    for (genvar k = 0; k < 6; k++) begin : g_line
        logic [1:0] st;
        logic       rt, claimed, done, erise;
        assign claimed  = i_CLAIM & win[k];
        assign done     = i_COMPLETE & (i_COMPLETE_ID == 3'(k)) & (st == IN_SERVICE);
        assign erise    = EDGE_MASK[k] & rise[k];
        assign pend[k]  = st == PENDING;
        assign insvc[k] = st == IN_SERVICE;
        // line state; an edge seen during service (or on the claim cycle) re-pends the line on completion
        always_ff @(posedge i_CLK or negedge i_RSTn)
            if (!i_RSTn) begin
                st <= IDLE;
                rt <= 1'b0;
            end else begin
                st <= (st == IDLE && req[k])    ? PENDING :
                      (st == PENDING && claimed) ? IN_SERVICE :
                      done                       ? ((rt | erise) ? PENDING : IDLE) : st;
                rt <= done ? 1'b0 : rt | (erise & ((st == IN_SERVICE) | claimed));
            end
    end

    // claim response, presented the cycle after the strobe
    always_ff @(posedge i_CLK or negedge i_RSTn)
        if (!i_RSTn) begin
            o_CLAIM_VALID <= 1'b0;
            o_CLAIM_ID    <= 3'd0;
        end else begin
            o_CLAIM_VALID <= claim_hit;
            o_CLAIM_ID    <= claim_hit ? win_id : 3'd0;
        end

    assign o_MEI_0      = pend[0];
    assign o_MEI_1      = pend[1];
    assign o_MEI_2      = pend[2];
    assign o_MEI_3      = pend[3];
    assign o_MEI_4      = pend[4];
    assign o_MEI_5      = pend[5];
    assign o_IN_SERVICE = insvc;
endmodule

// File: tb/tb_mei_gateway.sv
// tb_mei_gateway: directed plus randomized checks of mei_gateway against a behavioural model
module tb_mei_gateway;
    localparam int         SS       = 2;
    localparam logic [5:0] EM       = 6'b000001;
    localparam logic [5:0] POL      = 6'b101111;
    localparam logic [5:0] IDLE_RAW = 6'b010000;

    logic       i_CLK = 1'b0;
    logic       i_RSTn = 1'b0;
    logic [5:0] i_IRQ_RAW = IDLE_RAW;
    logic       i_CLAIM = 1'b0;
    logic       i_COMPLETE = 1'b0;
    logic [2:0] i_COMPLETE_ID = 3'd0;
    logic       o_MEI_0, o_MEI_1, o_MEI_2, o_MEI_3, o_MEI_4, o_MEI_5;
    logic       o_CLAIM_VALID;
    logic [2:0] o_CLAIM_ID;
    logic [5:0] o_IN_SERVICE;
    logic [5:0] mei;

    int checks = 0;
    int errors = 0;

    logic [5:0] m_sync [SS];
    logic [5:0] m_prev;
    int         m_st [6];
    bit         m_rt [6];
    bit         m_cv;
    int         m_cid;

    mei_gateway #(.SYNC_STAGES(SS), .EDGE_MASK(EM), .IRQ_POL(POL)) dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_IRQ_RAW(i_IRQ_RAW),
        .i_CLAIM(i_CLAIM), .i_COMPLETE(i_COMPLETE), .i_COMPLETE_ID(i_COMPLETE_ID),
        .o_MEI_0(o_MEI_0), .o_MEI_1(o_MEI_1), .o_MEI_2(o_MEI_2),
        .o_MEI_3(o_MEI_3), .o_MEI_4(o_MEI_4), .o_MEI_5(o_MEI_5),
        .o_CLAIM_VALID(o_CLAIM_VALID), .o_CLAIM_ID(o_CLAIM_ID), .o_IN_SERVICE(o_IN_SERVICE)
    );

    assign mei = {o_MEI_5, o_MEI_4, o_MEI_3, o_MEI_2, o_MEI_1, o_MEI_0};

    always #5 i_CLK = ~i_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_sync[i] = ~POL;
        m_prev = 6'd0;
        for (int k = 0; k < 6; k++) begin
            m_st[k] = 0;
            m_rt[k] = 0;
        end
        m_cv  = 0;
        m_cid = 0;
    endtask

    // 0 = idle, 1 = pending, 2 = in service; every decision uses the state before the edge
    task automatic model_edge();
        logic [5:0] act, rise;
        int win;
        act  = ~(m_sync[SS-1] ^ POL);
        rise = act & ~m_prev;
        win  = -1;
        for (int k = 0; k < 6; k++)
            if (m_st[k] == 1 && win < 0) win = k;
        for (int k = 0; k < 6; k++) begin
            bit edge_rise, req, done;
            edge_rise = EM[k] && rise[k];
            req  = EM[k] ? rise[k] : act[k];
            done = i_COMPLETE && int'(i_COMPLETE_ID) == k && m_st[k] == 2;
            if (m_st[k] == 0) begin
                if (req) m_st[k] = 1;
            end else if (m_st[k] == 1) begin
                if (i_CLAIM && win == k) begin
                    m_st[k] = 2;
                    if (edge_rise) m_rt[k] = 1;
                end
            end else if (done) begin
                m_st[k] = (m_rt[k] || edge_rise) ? 1 : 0;
                m_rt[k] = 0;
            end else if (edge_rise) m_rt[k] = 1;
        end
        m_cv  = i_CLAIM && win >= 0;
        m_cid = m_cv ? win : 0;
        for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = i_IRQ_RAW;
        m_prev = act;
    endtask

    task automatic check_all();
        logic [5:0] mp, ms;
        for (int k = 0; k < 6; k++) begin
            mp[k] = m_st[k] == 1;
            ms[k] = m_st[k] == 2;
        end
        chk("mei", 32'(mei), 32'(mp));
        chk("in_service", 32'(o_IN_SERVICE), 32'(ms));
        chk("claim_valid", 32'(o_CLAIM_VALID), 32'(m_cv));
        chk("claim_id", 32'(o_CLAIM_ID), 32'(m_cid));
    endtask

    task automatic step();
        @(posedge i_CLK);
        if (i_RSTn) model_edge();
        #1 check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_claim();
        i_CLAIM = 1'b1;
        step();
        i_CLAIM = 1'b0;
    endtask

    task automatic pulse_complete(input logic [2:0] id);
        i_COMPLETE = 1'b1;
        i_COMPLETE_ID = id;
        step();
        i_COMPLETE = 1'b0;
    endtask

    task automatic pulse_raw0();
        i_IRQ_RAW[0] = 1'b1;
        step();
        i_IRQ_RAW[0] = 1'b0;
        steps(3);
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        chk("reset_outputs", 32'({mei, o_CLAIM_VALID, o_CLAIM_ID, o_IN_SERVICE}), 32'd0);
        i_RSTn = 1'b1;

        // level line 2
        i_IRQ_RAW = IDLE_RAW | 6'b000100;
        steps(2);
        chk("lvl_mei2_early", 32'(o_MEI_2), 32'd0);
        step();
        chk("lvl_mei2_3rd_edge", 32'(o_MEI_2), 32'd1);
        pulse_claim();
        chk("lvl_claim_valid", 32'(o_CLAIM_VALID), 32'd1);
        chk("lvl_claim_id", 32'(o_CLAIM_ID), 32'd2);
        chk("lvl_mei2_cleared", 32'(o_MEI_2), 32'd0);
        chk("lvl_in_service", 32'(o_IN_SERVICE), 32'b000100);
        pulse_complete(3'd2);
        chk("lvl_idle_after_complete", 32'({o_MEI_2, o_IN_SERVICE}), 32'd0);
        step();
        chk("lvl_repend", 32'(o_MEI_2), 32'd1);
        i_IRQ_RAW = IDLE_RAW;
        steps(3);
        pulse_claim();
        pulse_complete(3'd2);
        steps(2);
        chk("lvl_drained", 32'(mei), 32'd0);

        // edge line 0: three pulses absorbed into one request
        pulse_raw0();
        pulse_raw0();
        pulse_raw0();
        steps(2);
        chk("edge_pending_once", 32'(mei), 32'b000001);
        pulse_claim();
        chk("edge_claim_id", 32'({o_CLAIM_VALID, o_CLAIM_ID}), 32'b1000);
        pulse_complete(3'd0);
        step();
        chk("edge_back_idle", 32'({mei, o_IN_SERVICE}), 32'd0);

        // edge line 0: edge during service retriggers on completion
        pulse_raw0();
        pulse_claim();
        pulse_raw0();
        chk("retrig_in_service", 32'(o_IN_SERVICE), 32'b000001);
        pulse_complete(3'd0);
        chk("retrig_repend", 32'(o_MEI_0), 32'd1);
        pulse_claim();
        pulse_complete(3'd0);

        // priority across lines 1, 3, 5
        i_IRQ_RAW = IDLE_RAW | 6'b101010;
        steps(3);
        chk("prio_pending", 32'(mei), 32'b101010);
        pulse_claim();
        chk("prio_first", 32'(o_CLAIM_ID), 32'd1);
        pulse_claim();
        chk("prio_second", 32'(o_CLAIM_ID), 32'd3);
        pulse_claim();
        chk("prio_third", 32'(o_CLAIM_ID), 32'd5);
        pulse_claim();
        chk("prio_empty", 32'({o_CLAIM_VALID, o_CLAIM_ID}), 32'd0);
        chk("prio_nested", 32'(o_IN_SERVICE), 32'b101010);
        i_IRQ_RAW = IDLE_RAW;
        steps(3);
        pulse_complete(3'd1);
        pulse_complete(3'd3);
        pulse_complete(3'd5);
        chk("prio_drained", 32'({mei, o_IN_SERVICE}), 32'd0);

        // stray completes, then simultaneous claim and complete
        pulse_complete(3'd3);
        pulse_complete(3'd7);
        chk("stray_complete", 32'({mei, o_IN_SERVICE}), 32'd0);
        i_IRQ_RAW = IDLE_RAW | 6'b000010;
        steps(3);
        pulse_claim();
        i_IRQ_RAW = IDLE_RAW | 6'b000100;
        steps(3);
        chk("simul_setup", 32'({mei, o_IN_SERVICE}), 32'b000100_000010);
        i_CLAIM = 1'b1;
        i_COMPLETE = 1'b1;
        i_COMPLETE_ID = 3'd1;
        step();
        i_CLAIM = 1'b0;
        i_COMPLETE = 1'b0;
        chk("simul_claim_id", 32'({o_CLAIM_VALID, o_CLAIM_ID}), 32'b1010);
        chk("simul_in_service", 32'(o_IN_SERVICE), 32'b000100);
        i_IRQ_RAW = IDLE_RAW;
        steps(3);
        pulse_complete(3'd2);

        // active-low line 4 and asynchronous reset
        steps(2);
        chk("pol_inactive", 32'(o_MEI_4), 32'd0);
        i_IRQ_RAW[4] = 1'b0;
        steps(2);
        chk("pol_early", 32'(o_MEI_4), 32'd0);
        step();
        chk("pol_active", 32'(o_MEI_4), 32'd1);
        pulse_claim();
        chk("pol_claim", 32'({o_CLAIM_VALID, o_CLAIM_ID, o_IN_SERVICE}), 32'b1100_010000);
        #3 i_RSTn = 1'b0;
        #1 chk("async_reset", 32'({mei, o_CLAIM_VALID, o_CLAIM_ID, o_IN_SERVICE}), 32'd0);
        model_reset();
        i_IRQ_RAW = IDLE_RAW;
        @(negedge i_CLK);
        i_RSTn = 1'b1;
        step();

        // randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            logic [5:0] flip;
            flip = 6'($urandom) & 6'($urandom) & 6'($urandom);
            i_IRQ_RAW = i_IRQ_RAW ^ flip;
            i_CLAIM = $urandom_range(0, 3) == 0;
            i_COMPLETE = $urandom_range(0, 2) == 0;
            i_COMPLETE_ID = 3'($urandom_range(0, 7));
            step();
        end
        i_CLAIM = 1'b0;
        i_COMPLETE = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
